// File: rtl/ysyx_25060170_ifu.sv
// ysyx_25060170_ifu: instruction fetch unit.
// Holds the PC and issues one word fetch at a time (REQ -> WAIT -> HOLD).
// The fetched word is presented to decode with a valid/ready handshake.
// A redirect from execute replaces the PC. A fetch that is already in flight
// is marked and its response is thrown away.
// Optional build macro YSYX_25060170_IFU_PERF_EN adds the fetch_cnt_o and
// stall_cnt_o performance counters.
module ysyx_25060170_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
`ifdef YSYX_25060170_IFU_PERF_EN
   ,output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] addr_q, addr_d;
    logic        drop_q, drop_d;

    // The PC is word aligned, so the low target bits are dropped.
    logic [31:0] redir_pc;
    logic        unused_redir_lo;
    assign redir_pc        = {redirect_pc_i[31:2], 2'b00};
    assign unused_redir_lo = ^redirect_pc_i[1:0];

    // State register: all fetch state, restored by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            addr_q  <= 32'h0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state, PC update and output decode; outputs depend only on state
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        inst_d          = inst_q;
        addr_d          = addr_q;
        drop_d          = drop_q;
        mem_req_valid_o = 1'b0;
        inst_valid_o    = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    state_d = S_WAIT;
                    addr_d  = pc_q;
                    // Accepted at the old PC while redirecting: the answer is stale
                    drop_d  = redirect_i;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid_i) begin
                    if (drop_q || redirect_i) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d  = mem_rsp_data_i;
                        state_d = S_HOLD;
                    end
                end else if (redirect_i) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                inst_valid_o = 1'b1;
                if (inst_ready_i) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
                // A redirect kills the held instruction whether or not it was taken
                if (redirect_i) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A redirect wins over the sequential pc+4 in every active state
        if (redirect_i && (state_q != S_IDLE)) begin
            pc_d = redir_pc;
        end
    end

    assign mem_req_addr_o = pc_q;
    assign inst_o         = inst_q;
    assign inst_addr_o    = addr_q;

`ifdef YSYX_25060170_IFU_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        deliver;

    assign deliver = (state_q == S_HOLD) && inst_ready_i;

    // Performance counters: delivered instructions and cycles spent on memory
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (deliver) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    // Without the performance option the unit has no counters.
`endif

endmodule

// File: tb/tb_ysyx_25060170_ifu.sv
// Self-checking bench for ysyx_25060170_ifu.
// It runs directed scenarios, then randomized traffic. Each cycle the outputs are
// compared with a transaction-level model of the fetch unit.
module tb_ysyx_25060170_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
`ifdef YSYX_25060170_IFU_PERF_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;
`endif

    always #5 clk = ~clk;

    ysyx_25060170_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .inst_valid_o    (inst_valid_o),
        .inst_ready_i    (inst_ready_i),
        .inst_o          (inst_o),
        .inst_addr_o     (inst_addr_o),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i)
`ifdef YSYX_25060170_IFU_PERF_EN
       ,.fetch_cnt_o     (fetch_cnt_o),
        .stall_cnt_o     (stall_cnt_o)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model. It describes the unit in terms of fetch transactions:
    // - m_boot: the bubble after reset.
    // - m_out: a fetch has been accepted by memory and no answer has come yet.
    // - m_stale: that outstanding fetch will be thrown away.
    // - m_hold: an instruction is being offered to decode.
    bit          m_boot, m_out, m_stale, m_hold;
    logic [31:0] m_pc, m_inst, m_addr, m_fetch, m_stall;

    task automatic m_reset();
        m_boot = 1; m_out = 0; m_stale = 0; m_hold = 0;
        m_pc = 32'h8000_0000; m_inst = 0; m_addr = 0; m_fetch = 0; m_stall = 0;
    endtask

    task automatic m_step();
        logic [31:0] npc;
        if (rst) begin
            m_reset();
            return;
        end
        if (m_boot) begin
            m_boot = 0;
            return;
        end
        npc = m_pc;
        if (m_hold) begin
            if (inst_ready_i) begin
                m_fetch = m_fetch + 1;
                npc = m_pc + 4;
                m_hold = 0;
            end
            if (redirect_i) m_hold = 0;
        end else if (!m_out) begin
            m_stall = m_stall + 1;
            if (mem_req_ready_i) begin
                m_out = 1;
                m_addr = m_pc;
                m_stale = redirect_i;
            end
        end else begin
            m_stall = m_stall + 1;
            if (mem_rsp_valid_i) begin
                m_out = 0;
                if (m_stale || redirect_i) m_stale = 0;
                else begin
                    m_hold = 1;
                    m_inst = mem_rsp_data_i;
                end
            end else if (redirect_i) begin
                m_stale = 1;
            end
        end
        if (redirect_i) npc = redirect_pc_i & 32'hFFFF_FFFC;
        m_pc = npc;
    endtask

    task automatic check_all();
        chk("req_valid", 32'(mem_req_valid_o), 32'(!(m_boot || m_out || m_hold)));
        chk("req_addr", mem_req_addr_o, m_pc);
        chk("inst_valid", 32'(inst_valid_o), 32'(m_hold));
        chk("inst", inst_o, m_inst);
        chk("inst_addr", inst_addr_o, m_addr);
`ifdef YSYX_25060170_IFU_PERF_EN
        chk("fetch_cnt", fetch_cnt_o, m_fetch);
        chk("stall_cnt", stall_cnt_o, m_stall);
`endif
    endtask

    // One clock: DUT and model advance on the edge; outputs are checked at negedge.
    task automatic cyc();
        @(posedge clk);
        m_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rsp_data_i = 0;
        inst_ready_i = 0; redirect_i = 0; redirect_pc_i = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        cyc();
        rst = 0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req_valid_o && n < 20) begin cyc(); n++; end
        chk(tag, 32'(mem_req_valid_o), 32'd1);
    endtask

    task automatic wait_inst(input string tag);
        int n = 0;
        while (!inst_valid_o && n < 40) begin cyc(); n++; end
        chk(tag, 32'(inst_valid_o), 32'd1);
    endtask

    initial begin
        int k, j, last;
        logic [31:0] sa, sd;

        m_reset();
        rst = 1;
        idle_inputs();
        cyc();
        cyc();
        // Reset values
        chk("rst_req_valid", 32'(mem_req_valid_o), 32'd0);
        chk("rst_req_addr", mem_req_addr_o, 32'h8000_0000);
        chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_inst_addr", inst_addr_o, 32'h0);

        // Zero-wait memory with a decode stage that is always ready
        do_reset();
        mem_req_ready_i = 1; mem_rsp_valid_i = 1; mem_rsp_data_i = 32'h0000_0013;
        inst_ready_i = 1;
        chk("idle_bubble", 32'(mem_req_valid_o), 32'd0);
        k = 0; j = 0; last = 0;
        for (int c = 1; c <= 9; c++) begin
            cyc();
            if (c == 1) chk("first_req", 32'(mem_req_valid_o), 32'd1);
            if (mem_req_valid_o) begin
                chk("seq_addr", mem_req_addr_o, 32'h8000_0000 + 32'(4 * k));
                k++;
            end
            if (inst_valid_o) begin
                chk("seq_iaddr", inst_addr_o, 32'h8000_0000 + 32'(4 * j));
                if (j > 0) chk("seq_gap", 32'(c - last), 32'd3);
                last = c;
                j++;
            end
        end
        chk("seq_nreq", 32'(k), 32'd3);
        chk("seq_ninst", 32'(j), 32'd3);

        // Decode back-pressure
        do_reset();
        mem_req_ready_i = 1; mem_rsp_valid_i = 1; mem_rsp_data_i = 32'h00A0_0093;
        wait_inst("bp_hold");
        sa = inst_addr_o; sd = inst_o;
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("bp_addr_stable", inst_addr_o, sa);
            chk("bp_inst_stable", inst_o, sd);
            chk("bp_no_req", 32'(mem_req_valid_o), 32'd0);
        end
        inst_ready_i = 1;
        cyc();
        inst_ready_i = 0;
        chk("bp_next_valid", 32'(mem_req_valid_o), 32'd1);
        chk("bp_next_addr", mem_req_addr_o, 32'h8000_0004);

        // Redirect while waiting for memory, before the response
        do_reset();
        mem_req_ready_i = 1; inst_ready_i = 1;
        cyc();
        cyc();
        chk("rw_in_wait", 32'(mem_req_valid_o), 32'd0);
        mem_req_ready_i = 0;
        redirect_i = 1; redirect_pc_i = 32'h8000_0103;
        cyc();
        redirect_i = 0;
        mem_rsp_valid_i = 1; mem_rsp_data_i = 32'hDEAD_BEEF;
        cyc();
        chk("rw_req_valid", 32'(mem_req_valid_o), 32'd1);
        chk("rw_req_addr", mem_req_addr_o, 32'h8000_0100);
        chk("rw_no_inst", 32'(inst_valid_o), 32'd0);
        mem_req_ready_i = 1; mem_rsp_data_i = 32'h0010_0093;
        wait_inst("rw_deliver");
        chk("rw_iaddr", inst_addr_o, 32'h8000_0100);
        chk("rw_inst", inst_o, 32'h0010_0093);

        // Redirect and acceptance in the same HOLD cycle
        do_reset();
        mem_req_ready_i = 1; mem_rsp_valid_i = 1; mem_rsp_data_i = 32'h13;
        wait_inst("rh_hold");
        inst_ready_i = 1; redirect_i = 1; redirect_pc_i = 32'h8000_0200;
        cyc();
        inst_ready_i = 0; redirect_i = 0;
        chk("rh_req_valid", 32'(mem_req_valid_o), 32'd1);
        chk("rh_req_addr", mem_req_addr_o, 32'h8000_0200);
`ifdef YSYX_25060170_IFU_PERF_EN
        chk("rh_fetch_cnt", fetch_cnt_o, 32'd1);
`endif

        // PC wrap
        do_reset();
        mem_req_ready_i = 1; mem_rsp_valid_i = 1;
        wait_inst("wr_hold");
        redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
        cyc();
        redirect_i = 0;
        chk("wr_target", mem_req_addr_o, 32'hFFFF_FFFC);
        inst_ready_i = 1;
        wait_inst("wr_deliver");
        chk("wr_iaddr", inst_addr_o, 32'hFFFF_FFFC);
        cyc();
        chk("wr_req_valid", 32'(mem_req_valid_o), 32'd1);
        chk("wr_req_addr", mem_req_addr_o, 32'h0000_0000);

        // Reset while a fetch is outstanding
        mem_rsp_valid_i = 0;
        cyc();
        chk("rm_in_wait", 32'(mem_req_valid_o), 32'd0);
        rst = 1; mem_rsp_valid_i = 1;
        cyc();
        rst = 0; mem_req_ready_i = 0;
        chk("rm_req_valid", 32'(mem_req_valid_o), 32'd0);
        chk("rm_req_addr", mem_req_addr_o, 32'h8000_0000);
        chk("rm_inst_valid", 32'(inst_valid_o), 32'd0);
        chk("rm_inst", inst_o, 32'h0);
        chk("rm_inst_addr", inst_addr_o, 32'h0);
        cyc();
        chk("rm_first_req", 32'(mem_req_valid_o), 32'd1);
        chk("rm_first_addr", mem_req_addr_o, 32'h8000_0000);
        cyc();
        chk("rm_rsp_ignored", 32'(inst_valid_o), 32'd0);

`ifdef YSYX_25060170_IFU_PERF_EN
        // Four instructions, memory accepts on the second request cycle
        begin
            int del = 0;
            bit prev = 0;
            do_reset();
            mem_rsp_valid_i = 1; mem_rsp_data_i = 32'h13; inst_ready_i = 1;
            for (int i = 0; i < 60 && del < 4; i++) begin
                mem_req_ready_i = mem_req_valid_o && prev;
                prev = mem_req_valid_o;
                if (inst_valid_o) del++;
                cyc();
            end
            chk("perf_fetch", fetch_cnt_o, 32'd4);
            chk("perf_stall", stall_cnt_o, 32'd12);
        end
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst             = ($urandom_range(0, 199) == 0);
            mem_req_ready_i = 1'($urandom_range(0, 1));
            mem_rsp_valid_i = ($urandom_range(0, 2) != 0);
            mem_rsp_data_i  = $urandom;
            inst_ready_i    = 1'($urandom_range(0, 1));
            redirect_i      = ($urandom_range(0, 9) == 0);
            redirect_pc_i   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ysyx_25060170_ifu.md
# ysyx_25060170_ifu

Instruction fetch unit of the NPC core: the producer of the instruction/PC pair consumed by the decode stage. It holds the PC and issues one word fetch at a time to instruction memory over a request/response handshake. It presents the fetched instruction and its address downstream with a valid/ready handshake, and it accepts PC redirects from the execute stage, discarding any fetch already in flight.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded by reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- mem_req_valid_o  out  1  fetch request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  32  fetch address (= pc)
- mem_rsp_valid_i  in  1  fetch data valid
- mem_rsp_data_i  in  32  fetched instruction word
- inst_valid_o  out  1  instruction valid to decode
- inst_ready_i  in  1  decode accepts instruction
- inst_o  out  32  instruction word
- inst_addr_o  out  32  address of inst_o
- redirect_i  in  1  PC redirect (jump/branch taken)
- redirect_pc_i  in  32  redirect target
- fetch_cnt_o  out  32  (only with YSYX_25060170_IFU_PERF_EN) instructions delivered
- stall_cnt_o  out  32  (only with YSYX_25060170_IFU_PERF_EN) cycles waiting on memory

## Operation
- Registers: pc[31:0], state, drop, inst_q[31:0], addr_q[31:0].
- pc[1:0] is always 2'b00. redirect_pc_i[1:0] is ignored. pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
- States:
  - IDLE: no outputs asserted; next state REQ unconditionally.
  - REQ: mem_req_valid_o=1, mem_req_addr_o=pc. If mem_req_ready_i, go to WAIT and set addr_q<=pc.
  - WAIT: wait for mem_rsp_valid_i. If drop or redirect_i, discard the response, clear drop, go to REQ. Otherwise inst_q<=mem_rsp_data_i and go to HOLD.
  - HOLD: inst_valid_o=1. If inst_ready_i, set pc<=pc+4 and go to REQ.
- Redirect (redirect_i=1), any state except IDLE: pc<=redirect_pc_i, overriding any pc+4 that cycle.
  - REQ without ready: stay in REQ; the address changes next cycle.
  - REQ with ready: the old-address request is accepted; go to WAIT with drop<=1.
  - WAIT without response: drop<=1.
  - WAIT with response: the response is discarded; go to REQ.
  - HOLD: the instruction is killed and the state goes to REQ. If inst_ready_i is high in the same cycle, the transfer still counts as accepted, but the next pc is redirect_pc_i.
- mem_rsp_valid_i outside WAIT is ignored.
- inst_o/inst_addr_o drive inst_q/addr_q and hold stable while inst_valid_o=1 and not accepted.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, drop=0, inst_q=0, addr_q=0.
- Output reset values: mem_req_valid_o=0, inst_valid_o=0, mem_req_addr_o=RESET_PC, inst_o=0, inst_addr_o=0, counters=0.
- Reset asserted mid-operation (any state, any outstanding request) restores all of the above on the next edge. An outstanding response after reset is ignored (the state is not WAIT).
- First request appears 1 cycle after rst deasserts (IDLE bubble).
- Request accepted at edge t; response sampled no earlier than cycle t+1; inst_valid_o high the cycle after the response edge.
- Minimum 3 cycles per instruction (REQ, WAIT, HOLD) with zero-wait memory and ready decode.
- Redirect to new request: a redirect in HOLD or WAIT+response puts mem_req_valid_o=1 with the new pc on the next cycle.
- All outputs are registered-state decodes; there is no combinational path from any input to any output.

## Configuration
- YSYX_25060170_IFU_PERF_EN defined:
  - fetch_cnt_o increments by 1 on each inst_valid_o&inst_ready_i.
  - stall_cnt_o increments every cycle in REQ or WAIT.
  - Both wrap at 2^32 and are cleared by rst.
- Undefined: both ports and both counters are absent; all other behaviour is identical.

## Test plan
- Reset, zero-wait memory returning 32'h0000_0013, inst_ready_i=1:
  - mem_req_addr_o sequence 8000_0000, 8000_0004, 8000_0008.
  - inst_valid_o every 3rd cycle with matching inst_addr_o.
- Decode back-pressure: inst_ready_i=0 for 5 cycles in HOLD -> inst_o/inst_addr_o stable, no new mem request; release -> next address 8000_0004.
- Redirect in WAIT to 32'h8000_0103 before the response -> response data discarded, next request address 8000_0100, delivered inst_addr_o=8000_0100.
- Redirect and inst_ready_i in the same HOLD cycle, target 8000_0200 -> transfer counted, next request 8000_0200 (not pc+4).
- PC wrap and reset mid-operation:
  - Redirect to FFFF_FFFC, accept -> next request 0000_0000.
  - Assert rst while in WAIT -> outputs return to reset values; first request after release at RESET_PC.
- With YSYX_25060170_IFU_PERF_EN, 4 delivered instructions with 1-cycle memory accept delay each -> fetch_cnt_o=4, stall_cnt_o=12.
